next_line_fill_engine: RTL
==========================

# next_line_fill_engine

Memory-side fill engine for the next-line prefetcher. It accepts prefetch-miss requests, queues up to two line-aligned fetch addresses, and issues one burst read per line to the memory port. It assembles the returned beats into a full block and presents it with a one-cycle `block_ready` pulse, which the prefetcher uses to fill its buffer.

## Interface
Parameters:
- `block_size_byte`, 16, line size in bytes.
- `mem_data_width`, 32, memory read beat width in bits.
- `block_offset_index`, log2(`block_size_byte`) (4), number of address offset bits.
- `beats`, `block_size_byte`*8/`mem_data_width` (4), beats per line. Must be an integer ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `prefetch_miss`  in  1  request strobe, sampled every edge.
- `prefetch_address`  in  32  request byte address. Low `block_offset_index` bits are ignored.
- `mem_req`  out  1  read request; held until granted.
- `mem_addr`  out  32  line-aligned read address; stable while `mem_req`=1.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rdata`  in  `mem_data_width`  read beat data.
- `block`  out  `block_size_byte`*8  assembled line.
- `block_addr`  out  32  aligned address of `block`.
- `block_ready`  out  1  one-cycle pulse; `block`/`block_addr` valid.
- `busy`  out  1  queue non-empty or FSM not IDLE.
- `drop_count`  out  8  requests dropped because the queue was full; saturates at 255.

## Operation
- Alignment: aligned = {`prefetch_address`[31:`block_offset_index`], zeros}.
- Request queue: 2-entry FIFO of aligned addresses. The head entry is the in-flight request.
- Push on each edge where `prefetch_miss`=1:
  - If the aligned address equals any valid entry, including the head, the request is a duplicate. It is silently discarded and not counted.
  - If the queue is full (count 2, evaluated before any same-edge pop) and the request is not a duplicate, it is discarded and `drop_count` increments, saturating at 255.
  - Otherwise the address is written at the tail.
- FSM states: IDLE, REQ, DATA, DONE.
  - IDLE: if the queue is non-empty, go to REQ. `mem_addr` is loaded from the head and the beat counter is cleared.
  - REQ: `mem_req`=1. On an edge with `mem_gnt`=1, go to DATA and drop `mem_req`. `mem_rvalid` is ignored in REQ.
  - DATA: each edge with `mem_rvalid`=1 writes `mem_rdata` into `block`[k*`mem_data_width` +: `mem_data_width`] and increments k. Beat 0 is the least significant. On the beat where k=`beats`-1, go to DONE.
  - DONE: `block_ready`=1 and `block_addr`=head for exactly this cycle. The head is popped on the edge leaving DONE, then the FSM returns to IDLE.
- A push and a pop on the same edge are both performed. Count is unchanged, and the order is preserved.
- `block` holds its last value outside DONE. Consumers may sample it only during `block_ready`.
- Reset (asynchronous, any state):
  - FSM returns to IDLE and the queue is emptied; an in-flight fill is abandoned with no `block_ready`.
  - All outputs go to 0 immediately: `mem_req`, `mem_addr`, `block`, `block_addr`, `block_ready`, `busy`, `drop_count`.
  - Beats arriving after reset are ignored.

## Timing
- Request at edge 0, with the queue empty and the FSM in IDLE:
  - After edge 0: entry queued, `busy`=1.
  - After edge 1: REQ, `mem_req`=1.
  - `mem_gnt` sampled at edge 2 moves the FSM to DATA.
  - Beats on edges 3..6 (four beats, back to back).
  - After edge 6: DONE; `block_ready` is high for one cycle.
  - After edge 7: IDLE.
  - Minimum latency from request to `block_ready`: 6 cycles.
- Queued second request: next `mem_req` rises one cycle after DONE (DONE→IDLE→REQ), i.e. at least 2 idle cycles between fills.
- `mem_gnt` and `mem_rvalid` can stall arbitrarily. Gaps between beats are allowed.
- `busy` drops in the cycle after the DONE of the last queued entry.
- `drop_count` updates on the edge where the request is sampled.

## Test plan
- Single fill: request 0x0000_1238, then `mem_gnt` at edge 2, then beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> `mem_addr`=0x0000_1230; one-cycle `block_ready` with `block`=0x44444444_33333333_22222222_11111111 and `block_addr`=0x0000_1230.
- Back-to-back fills: requests 0x100 and 0x200 on consecutive edges, with grant stalled 5 cycles -> two fills in order 0x100 then 0x200; two `block_ready` pulses; `drop_count`=0.
- Overflow and duplicates: requests 0x100, 0x105, 0x200, 0x300 on consecutive edges while the first is ungranted -> 0x105 discarded as a duplicate; 0x300 dropped; `drop_count`=1; only 0x100 and 0x200 fetched.
- Saturation: 300 non-duplicate requests while full -> `drop_count`=255.
- Reset mid-fill: `rst_n` low after beat 2 of a fill -> `mem_req`, `block_ready`, `busy`, and `drop_count` all 0 immediately. Remaining beats after release produce no `block_ready`, and the next request fills normally.
- Beat gaps: `mem_rvalid` high only on every third cycle -> `block` is assembled correctly and `block_ready` fires exactly once.

Source files
------------

// File: rtl/next_line_fill_engine_if.sv
// Bus bundle between the next-line prefetcher / memory port and the fill engine.
// slave  : fill engine side (takes requests and memory responses, drives memory
//          requests and the assembled block).
// master : prefetcher / memory / testbench side.
// Signals:
//   prefetch_miss, prefetch_address         request strobe and byte address
//   mem_req, mem_addr, mem_gnt              read request handshake
//   mem_rvalid, mem_rdata                   read beats
//   block, block_addr, block_ready          assembled line and its one-cycle strobe
//   busy, drop_count                        status
interface next_line_fill_engine_if #(
   parameter int block_size_byte = 16,
   parameter int mem_data_width  = 32
);
   logic                         prefetch_miss;
   logic [31:0]                  prefetch_address;
   logic                         mem_req;
   logic [31:0]                  mem_addr;
   logic                         mem_gnt;
   logic                         mem_rvalid;
   logic [mem_data_width-1:0]    mem_rdata;
   logic [block_size_byte*8-1:0] block;
   logic [31:0]                  block_addr;
   logic                         block_ready;
   logic                         busy;
   logic [7:0]                   drop_count;

   modport slave (
      input  prefetch_miss, prefetch_address, mem_gnt, mem_rvalid, mem_rdata,
      output mem_req, mem_addr, block, block_addr, block_ready, busy, drop_count
   );

   modport master (
      output prefetch_miss, prefetch_address, mem_gnt, mem_rvalid, mem_rdata,
      input  mem_req, mem_addr, block, block_addr, block_ready, busy, drop_count
   );
endinterface

// File: rtl/next_line_fill_engine.sv
// Memory-side fill engine for the next-line prefetcher.
// Queues up to two line-aligned fetch addresses, issues one burst read per line,
// assembles the returned beats (beat 0 least significant) and presents the line
// with a one-cycle block_ready pulse.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    next_line_fill_engine_if.slave (request, memory and block signals)
//
// state | meaning
// IDLE  | waiting for a queued address; loads mem_addr from the queue head
// REQ   | mem_req high until mem_gnt
// DATA  | collecting beats on mem_rvalid
// DONE  | block_ready pulse; head popped on the edge leaving this state
module next_line_fill_engine #(
   parameter int block_size_byte    = 16,
   parameter int mem_data_width     = 32,
   parameter int block_offset_index = $clog2(block_size_byte),
   parameter int beats              = block_size_byte * 8 / mem_data_width
) (
   input logic                      clk,
   input logic                      rst_n,
   next_line_fill_engine_if.slave   bus
);
   localparam int blk_w = block_size_byte * 8;
   localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
   localparam logic [cnt_w-1:0] last_beat_idx = cnt_w'(beats - 1);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

   state_t            state_q, state_d;
   logic [31:0]       q0_q, q1_q;
   logic [1:0]        count_q;
   logic [cnt_w-1:0]  beat_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       block_addr_q;
   logic [blk_w-1:0]  block_q;
   logic [7:0]        drop_q;

   logic [31:0]       aligned;
   logic              dup, full, push, drop_inc, pop, last_beat;

   assign aligned  = {bus.prefetch_address[31:block_offset_index], {block_offset_index{1'b0}}};
   // The head stays a valid entry until the pop edge, so a repeat of the line
   // being filled is a duplicate even while DONE is popping it.
   assign dup      = ((count_q != 2'd0) && (q0_q == aligned)) ||
                     ((count_q == 2'd2) && (q1_q == aligned));
   assign full     = (count_q == 2'd2);
   assign push     = bus.prefetch_miss && !dup && !full;
   assign drop_inc = bus.prefetch_miss && !dup && full;
   assign pop      = (state_q == DONE);
   assign last_beat = (state_q == DATA) && bus.mem_rvalid && (beat_q == last_beat_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      bus.mem_req     = 1'b0;
      bus.block_ready = 1'b0;
      case (state_q)
         IDLE: if (count_q != 2'd0) state_d = REQ;
         REQ: begin
            bus.mem_req = 1'b1;
            if (bus.mem_gnt) state_d = DATA;
         end
         DATA: if (last_beat) state_d = DONE;
         DONE: begin
            bus.block_ready = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Two-entry FIFO kept as a shift pair: q0 is always the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0_q    <= '0;
         q1_q    <= '0;
         count_q <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) q0_q <= aligned;
               else                 q1_q <= aligned;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               q0_q    <= q1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  q0_q <= aligned;
               end else begin
                  q0_q <= q1_q;
                  q1_q <= aligned;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q   <= '0;
         beat_q       <= '0;
         block_q      <= '0;
         block_addr_q <= '0;
      end else begin
         if ((state_q == IDLE) && (count_q != 2'd0)) begin
            mem_addr_q <= q0_q;
            beat_q     <= '0;
         end
         if ((state_q == DATA) && bus.mem_rvalid) begin
            block_q[int'(beat_q)*mem_data_width +: mem_data_width] <= bus.mem_rdata;
            beat_q <= beat_q + cnt_w'(1);
         end
         if (last_beat) block_addr_q <= q0_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         drop_q <= '0;
      else if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
   end

   assign bus.mem_addr   = mem_addr_q;
   assign bus.block      = block_q;
   assign bus.block_addr = block_addr_q;
   assign bus.busy       = (count_q != 2'd0) || (state_q != IDLE);
   assign bus.drop_count = drop_q;

endmodule
